stage_draw_engine: RTL and testbench
====================================

Name: stage_draw_engine

Overview:
- Pixel-drawing datapath that sits directly downstream of the game control FSM.
- Performs full-screen background copies (title, stage and win screens) from three background ROM banks into the 160x120 VGA adapter.
- Draws individual 10x10 stage tiles from a tile ROM into an 11x11 grid at the position given by the tile counter.
- Reports completion through a one-cycle `finished` pulse, which the control FSM uses to advance its state.

Parameters:
- SCREEN_W, 160, background width in pixels
- SCREEN_H, 120, background height in pixels
- TILE_SIZE, 10, tile edge in pixels
- GRID_W, 11, tiles per grid row/column (121 tiles)
- X_OFF, 25, screen x of grid column 0
- Y_OFF, 5, screen y of grid row 0

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- copy_enable  in  1  level request: copy background bank
- memory_select  in  2  background bank for a copy (0 title, 1 stage, 2 win; 3 treated as 0)
- tile_enable  in  1  level request: draw one tile
- tile_select  in  4  tile graphic number (0..15)
- tile_index  in  7  grid position 0..120, row-major
- bg_bank  out  2  bank select to background ROMs
- bg_addr  out  15  background ROM address, y*SCREEN_W+x
- bg_data  in  3  background colour; valid 1 cycle after bg_addr
- tile_addr  out  11  tile ROM address, tile_select*100 + py*10 + px
- tile_data  in  3  tile colour; valid 1 cycle after tile_addr
- x  out  8  VGA x
- y  out  7  VGA y
- colour  out  3  VGA colour
- plot  out  1  VGA write enable
- finished  out  1  one-cycle done pulse
- busy  out  1  high from accepted request until `finished`

Behaviour:
- **Reset (asynchronous, any time, including mid-operation):**
  - State goes to IDLE.
  - All outputs are 0: `bg_addr`, `tile_addr`, `x`, `y`, `colour`, `plot`, `finished`, `busy`, `bg_bank`.
  - The in-flight operation is abandoned; no `finished` pulse is generated for it.
- **States:** IDLE, COPY, TILE, DRAIN, DONE.
- **IDLE:**
  - Samples requests at each clock edge. If `copy_enable` is high, go to COPY. Otherwise, if `tile_enable` is high, go to TILE. Otherwise stay in IDLE.
  - If both requests are high, `copy_enable` wins.
  - Captures `memory_select`, `tile_select` and `tile_index` at the accepting edge. Later input changes are ignored until DONE.
- **Request style:**
  - Requests are levels held by the control FSM.
  - DONE always returns to IDLE, so a request still high in IDLE starts a new operation. Back-to-back tile draws therefore have a 1-cycle IDLE gap.
- **COPY:**
  - Scans x 0..159 (inner loop), y 0..119 (outer loop), issuing one address per cycle: 19200 cycles.
  - Moves to DRAIN after issuing address 19199.
- **TILE:**
  - Grid position: row = tile_index/11, col = tile_index%11. Division may be implemented as an iterative counter, provided tile latency stays within the bound below.
  - Origin: ox = X_OFF + col*10, oy = Y_OFF + row*10.
  - Scans px 0..9 (inner), py 0..9 (outer): 100 address cycles, then DRAIN.
  - If `tile_index` > 120: no plot; go directly to DONE.
- **Pipeline:**
  - ROM latency is fixed at 1 cycle.
  - `plot`, `x`, `y`, `colour` are registered. They assert on the cycle after the corresponding address, with `colour` taken from `bg_data` or `tile_data`.
  - DRAIN covers the final pixel's plot.
- **DONE:** `finished`=1 for exactly one cycle, `busy`=0, `plot`=0; then IDLE.
- **Copy timing:**
  - Accepting edge E0.
  - Addresses are issued in cycles 1..19200.
  - `plot` is high in cycles 2..19201, with no gaps.
  - `finished` is high in cycle 19202.
- **Tile timing:**
  - Tile plots are contiguous (100 cycles).
  - `finished` is high no later than 16 cycles after the last plot.
- **Coordinates:** x/y never exceed 159/119.
- **Address arithmetic:** 15-bit `bg_addr` and 11-bit `tile_addr`, maximum 1599, no overflow.

Test Plan:
- Reset mid-copy at pixel 500 -> all outputs 0 next cycle. Release reset with requests low -> IDLE; no `finished`.
- `copy_enable`=1, `memory_select`=2 -> `bg_bank`=2.
  - First plot: x=0, y=0.
  - Last plot: x=159, y=119, `bg_addr` 19199 issued one cycle earlier.
  - Exactly 19200 plots.
  - `finished` pulses once, 19202 cycles after acceptance.
- `tile_enable`=1, `tile_select`=3, `tile_index`=12 -> 100 plots.
  - x spans 35..44, y spans 15..24.
  - First `tile_addr`=300, last=399.
  - `colour` equals `tile_data` delayed one cycle.
- `tile_index`=120 -> x spans 125..134, y spans 105..114. `tile_index`=121 -> zero plots, single `finished` pulse.
- `copy_enable` and `tile_enable` both high -> copy executes. `tile_select` toggled during the copy has no effect.
- `tile_enable` held high across two operations with `tile_index` stepping 0 to 1 in the `finished` cycle -> second tile drawn at x 35..44, y 5..14, after a 1-cycle IDLE gap.

Source files
------------

// File: rtl/stage_draw_engine_if.sv
// Request, ROM and VGA signals of the stage draw engine.
// slave = engine side, master = control FSM / ROM / VGA side.
interface stage_draw_engine_if;
  logic        copy_enable;
  logic [1:0]  memory_select;
  logic        tile_enable;
  logic [3:0]  tile_select;
  logic [6:0]  tile_index;
  logic [1:0]  bg_bank;
  logic [14:0] bg_addr;
  logic [2:0]  bg_data;
  logic [10:0] tile_addr;
  logic [2:0]  tile_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        finished;
  logic        busy;

  modport slave (
    input  copy_enable, memory_select, tile_enable, tile_select, tile_index,
    input  bg_data, tile_data,
    output bg_bank, bg_addr, tile_addr, x, y, colour, plot, finished, busy
  );

  modport master (
    output copy_enable, memory_select, tile_enable, tile_select, tile_index,
    output bg_data, tile_data,
    input  bg_bank, bg_addr, tile_addr, x, y, colour, plot, finished, busy
  );
endinterface

// File: rtl/stage_draw_engine.sv
// Background copy / grid tile blitter: one ROM address per cycle, plot one cycle later.
// Requests are held levels; no backpressure, `finished` pulses once per accepted request.
module stage_draw_engine #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int TILE_SIZE = 10,
  parameter int GRID_W    = 11,
  parameter int X_OFF     = 25,
  parameter int Y_OFF     = 5
) (
  input  logic               clock,
  input  logic               reset,
  stage_draw_engine_if.slave bus
);

  localparam logic [7:0] X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST   = 7'(SCREEN_H - 1);
  localparam logic [3:0] T_LAST   = 4'(TILE_SIZE - 1);
  localparam logic [6:0] IDX_LAST = 7'(GRID_W * GRID_W - 1);
  localparam logic [6:0] GRID_W7  = 7'(GRID_W);

  typedef enum logic [2:0] {IDLE, COPY, TILE, DRAIN, DONE} state_t;

  state_t      state, state_nxt;

  logic [1:0]  bank_r;
  logic [14:0] bg_addr_r;
  logic [10:0] tile_addr_r;
  logic [7:0]  ax, ox;
  logic [6:0]  ay;
  logic [3:0]  px, py;
  logic [7:0]  x_r;
  logic [6:0]  y_r;
  logic [2:0]  colour_r;
  logic        plot_r, finished_r, busy_r;

  logic [3:0]  grid_row, grid_col;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic [10:0] tile_base;
  logic        idx_ok, copy_last, tile_last;

  // Grid origin of the requested tile, valid only when idx_ok.
  always_comb begin
    grid_row  = 4'(bus.tile_index / GRID_W7);
    grid_col  = 4'(bus.tile_index % GRID_W7);
    origin_x  = 8'(X_OFF) + 8'(grid_col) * 8'(TILE_SIZE);
    origin_y  = 7'(Y_OFF) + 7'(grid_row) * 7'(TILE_SIZE);
    tile_base = 11'(bus.tile_select) * 11'(TILE_SIZE * TILE_SIZE);
    idx_ok    = (bus.tile_index <= IDX_LAST);
    copy_last = (ax == X_LAST) && (ay == Y_LAST);
    tile_last = (px == T_LAST) && (py == T_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.copy_enable)      state_nxt = COPY;
        else if (bus.tile_enable) state_nxt = idx_ok ? TILE : DONE;
      end
      COPY:    if (copy_last) state_nxt = DRAIN;
      TILE:    if (tile_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_r      <= '0;
      bg_addr_r   <= '0;
      tile_addr_r <= '0;
      ax          <= '0;
      ay          <= '0;
      ox          <= '0;
      px          <= '0;
      py          <= '0;
      x_r         <= '0;
      y_r         <= '0;
      colour_r    <= '0;
      plot_r      <= 1'b0;
      finished_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      plot_r     <= 1'b0;
      finished_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.copy_enable) begin
            bank_r    <= (bus.memory_select == 2'd3) ? 2'd0 : bus.memory_select;
            bg_addr_r <= '0;
            ax        <= '0;
            ay        <= '0;
            busy_r    <= 1'b1;
          end else if (bus.tile_enable) begin
            if (idx_ok) begin
              tile_addr_r <= tile_base;
              ox          <= origin_x;
              ax          <= origin_x;
              ay          <= origin_y;
              px          <= '0;
              py          <= '0;
              busy_r      <= 1'b1;
            end else begin
              // Off-grid index: nothing to draw, report completion straight away.
              finished_r  <= 1'b1;
            end
          end
        end
        COPY: begin
          plot_r   <= 1'b1;
          x_r      <= ax;
          y_r      <= ay;
          colour_r <= bus.bg_data;
          if (!copy_last) begin
            bg_addr_r <= bg_addr_r + 15'd1;
            if (ax == X_LAST) begin
              ax <= '0;
              ay <= ay + 7'd1;
            end else begin
              ax <= ax + 8'd1;
            end
          end
        end
        TILE: begin
          plot_r   <= 1'b1;
          x_r      <= ax;
          y_r      <= ay;
          colour_r <= bus.tile_data;
          if (!tile_last) begin
            tile_addr_r <= tile_addr_r + 11'd1;
            if (px == T_LAST) begin
              px <= '0;
              py <= py + 4'd1;
              ax <= ox;
              ay <= ay + 7'd1;
            end else begin
              px <= px + 4'd1;
              ax <= ax + 8'd1;
            end
          end
        end
        DRAIN: begin
          finished_r <= 1'b1;
          busy_r     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.bg_bank   = bank_r;
  assign bus.bg_addr   = bg_addr_r;
  assign bus.tile_addr = tile_addr_r;
  assign bus.x         = x_r;
  assign bus.y         = y_r;
  assign bus.colour    = colour_r;
  assign bus.plot      = plot_r;
  assign bus.finished  = finished_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_stage_draw_engine.sv
// Directed bench for stage_draw_engine with combinational ROM models and a plot monitor.
module tb_stage_draw_engine;
  logic clock = 1'b0;
  logic reset;

  stage_draw_engine_if bus();

  stage_draw_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] bg_rom(input logic [14:0] a, input logic [1:0] b);
    return a[2:0] ^ a[5:3] ^ {1'b0, b};
  endfunction

  function automatic logic [2:0] tile_rom(input logic [10:0] a);
    return a[2:0] ^ a[6:4];
  endfunction

  assign bus.bg_data   = bg_rom(bus.bg_addr, bus.bg_bank);
  assign bus.tile_data = tile_rom(bus.tile_addr);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Plot monitor
  bit         mon_on = 1'b0;
  bit         mon_tile;
  logic [1:0] mon_bank;
  int         mon_sel, mon_ox, mon_oy;
  int n_plot, n_fin, gaps, col_bad, dly_bad, coord_bad;
  int first_x, first_y, first_cyc, last_x, last_y, last_cyc, fin_cyc;
  int min_x, max_x, min_y, max_y, first_taddr, last_taddr, last_baddr;
  logic        prev_plot = 1'b0;
  logic [2:0]  prev_tdata = '0;
  logic [10:0] prev_taddr = '0;
  logic [14:0] prev_baddr = '0;

  task automatic mon_clear();
    n_plot = 0; n_fin = 0; gaps = 0; col_bad = 0; dly_bad = 0; coord_bad = 0;
    first_x = -1; first_y = -1; first_cyc = -1; last_x = -1; last_y = -1; last_cyc = -1;
    fin_cyc = -1; min_x = 999; max_x = -1; min_y = 999; max_y = -1;
    first_taddr = -1; last_taddr = -1; last_baddr = -1;
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      if (bus.plot) begin
        if (n_plot == 0) begin
          first_x = int'(bus.x); first_y = int'(bus.y); first_cyc = cyc;
          first_taddr = int'(prev_taddr);
        end else if (!prev_plot) begin
          gaps++;
        end
        n_plot++;
        if (int'(bus.x) < min_x) min_x = int'(bus.x);
        if (int'(bus.x) > max_x) max_x = int'(bus.x);
        if (int'(bus.y) < min_y) min_y = int'(bus.y);
        if (int'(bus.y) > max_y) max_y = int'(bus.y);
        last_x = int'(bus.x); last_y = int'(bus.y); last_cyc = cyc;
        last_taddr = int'(prev_taddr); last_baddr = int'(prev_baddr);
        if (bus.x > 8'd159 || bus.y > 7'd119) coord_bad++;
        if (mon_tile) begin
          if (bus.colour != tile_rom(11'(mon_sel * 100 + (int'(bus.y) - mon_oy) * 10
                                         + (int'(bus.x) - mon_ox)))) col_bad++;
          if (bus.colour != prev_tdata) dly_bad++;
        end else begin
          if (bus.colour != bg_rom(15'(int'(bus.y) * 160 + int'(bus.x)), mon_bank)) col_bad++;
        end
      end
      if (bus.finished) begin
        n_fin++;
        fin_cyc = cyc;
      end
    end
    prev_plot  = bus.plot;
    prev_tdata = bus.tile_data;
    prev_taddr = bus.tile_addr;
    prev_baddr = bus.bg_addr;
  end

  // Raise requests just after an edge; acc is the cycle count before the accepting edge.
  task automatic launch(input bit cp, input bit tl, input logic [1:0] ms,
                        input logic [3:0] ts, input logic [6:0] ti,
                        input int ox, input int oy, input logic [1:0] exp_bank);
    @(posedge clock); #1;
    bus.copy_enable   = cp;
    bus.tile_enable   = tl;
    bus.memory_select = ms;
    bus.tile_select   = ts;
    bus.tile_index    = ti;
    mon_clear();
    mon_tile = !cp;
    mon_bank = exp_bank;
    mon_sel  = int'(ts);
    mon_ox   = ox;
    mon_oy   = oy;
    mon_on   = 1'b1;
    @(posedge clock);
    acc = cyc;
    #1;
  endtask

  task automatic wait_fin(input string tag, input int limit, input bit toggle);
    int i;
    i = 0;
    while (n_fin == 0 && i < limit) begin
      @(negedge clock); #1;
      if (toggle) begin
        bus.tile_select = ~bus.tile_select;
        bus.tile_index  = 7'(i % 121);
      end
      i++;
    end
    check_eq(tag, int'(n_fin > 0), 1);
  endtask

  task automatic end_op();
    bus.copy_enable = 1'b0;
    bus.tile_enable = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    mon_on = 1'b0;
  endtask

  initial begin
    int i;
    int f1;
    reset = 1'b1;
    bus.copy_enable = 1'b0; bus.tile_enable = 1'b0;
    bus.memory_select = '0; bus.tile_select = '0; bus.tile_index = '0;
    mon_clear();
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_plot", int'(bus.plot), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_finished", int'(bus.finished), 0);
    reset = 1'b0;

    // Reset in the middle of a copy
    launch(1'b1, 1'b0, 2'd1, 4'd0, 7'd0, 0, 0, 2'd1);
    i = 0;
    while (bus.bg_addr != 15'd500 && i < 1000) begin
      @(negedge clock); #1; i++;
    end
    check_eq("mid_copy_addr", int'(bus.bg_addr), 500);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_bg_addr", int'(bus.bg_addr), 0);
    check_eq("mid_rst_xy_colour", int'({bus.x, bus.y, bus.colour}), 0);
    check_eq("mid_rst_flags", int'({bus.plot, bus.finished, bus.busy}), 0);
    check_eq("mid_rst_bank_taddr", int'({bus.bg_bank, bus.tile_addr}), 0);
    bus.copy_enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    n_fin = 0; n_plot = 0;
    repeat (6) @(negedge clock);
    #1;
    check_eq("post_rst_finished", n_fin, 0);
    check_eq("post_rst_plots", n_plot, 0);
    check_eq("post_rst_busy", int'(bus.busy), 0);
    mon_on = 1'b0;

    // Full copy of the win screen
    launch(1'b1, 1'b0, 2'd2, 4'd0, 7'd0, 0, 0, 2'd2);
    check_eq("copy_bank", int'(bus.bg_bank), 2);
    check_eq("copy_busy", int'(bus.busy), 1);
    wait_fin("copy_finish_seen", 19400, 1'b0);
    end_op();
    check_eq("copy_first_x", first_x, 0);
    check_eq("copy_first_y", first_y, 0);
    check_eq("copy_last_x", last_x, 159);
    check_eq("copy_last_y", last_y, 119);
    check_eq("copy_last_addr", last_baddr, 19199);
    check_eq("copy_plots", n_plot, 19200);
    check_eq("copy_gaps", gaps, 0);
    check_eq("copy_first_plot_cyc", first_cyc - acc, 2);
    check_eq("copy_last_plot_cyc", last_cyc - acc, 19201);
    check_eq("copy_fin_cyc", fin_cyc - acc, 19202);
    check_eq("copy_fin_count", n_fin, 1);
    check_eq("copy_colour_bad", col_bad, 0);
    check_eq("copy_coord_bad", coord_bad, 0);

    // Tile 3 at grid index 12 (row 1, col 1)
    launch(1'b0, 1'b1, 2'd0, 4'd3, 7'd12, 35, 15, 2'd0);
    wait_fin("tile12_finish_seen", 300, 1'b0);
    end_op();
    check_eq("tile12_plots", n_plot, 100);
    check_eq("tile12_min_x", min_x, 35);
    check_eq("tile12_max_x", max_x, 44);
    check_eq("tile12_min_y", min_y, 15);
    check_eq("tile12_max_y", max_y, 24);
    check_eq("tile12_first_taddr", first_taddr, 300);
    check_eq("tile12_last_taddr", last_taddr, 399);
    check_eq("tile12_gaps", gaps, 0);
    check_eq("tile12_colour_bad", col_bad, 0);
    check_eq("tile12_delay_bad", dly_bad, 0);
    check_eq("tile12_fin_latency_ok", int'((fin_cyc - last_cyc) <= 16 && fin_cyc > last_cyc), 1);
    check_eq("tile12_fin_count", n_fin, 1);

    // Last grid cell
    launch(1'b0, 1'b1, 2'd0, 4'd15, 7'd120, 125, 105, 2'd0);
    wait_fin("tile120_finish_seen", 300, 1'b0);
    end_op();
    check_eq("tile120_plots", n_plot, 100);
    check_eq("tile120_min_x", min_x, 125);
    check_eq("tile120_max_x", max_x, 134);
    check_eq("tile120_min_y", min_y, 105);
    check_eq("tile120_max_y", max_y, 114);
    check_eq("tile120_colour_bad", col_bad, 0);

    // Off-grid index
    launch(1'b0, 1'b1, 2'd0, 4'd1, 7'd121, 0, 0, 2'd0);
    wait_fin("tile121_finish_seen", 50, 1'b0);
    end_op();
    check_eq("tile121_plots", n_plot, 0);
    check_eq("tile121_fin_count", n_fin, 1);

    // Both requests high, bank 3 reads as bank 0, tile inputs wiggle during copy
    launch(1'b1, 1'b1, 2'd3, 4'd5, 7'd7, 0, 0, 2'd0);
    check_eq("both_bank", int'(bus.bg_bank), 0);
    wait_fin("both_finish_seen", 19400, 1'b1);
    end_op();
    check_eq("both_plots", n_plot, 19200);
    check_eq("both_max_x", max_x, 159);
    check_eq("both_max_y", max_y, 119);
    check_eq("both_colour_bad", col_bad, 0);
    check_eq("both_fin_count", n_fin, 1);

    // Back-to-back tiles with tile_index stepping in the finished cycle
    launch(1'b0, 1'b1, 2'd0, 4'd2, 7'd0, 25, 5, 2'd0);
    wait_fin("b2b_first_finish_seen", 300, 1'b0);
    check_eq("b2b_first_plots", n_plot, 100);
    check_eq("b2b_first_min_x", min_x, 25);
    f1 = fin_cyc;
    bus.tile_index = 7'd1;
    mon_clear();
    mon_ox = 35;
    mon_oy = 5;
    wait_fin("b2b_second_finish_seen", 300, 1'b0);
    end_op();
    check_eq("b2b_gap", first_cyc - f1, 3);
    check_eq("b2b_plots", n_plot, 100);
    check_eq("b2b_min_x", min_x, 35);
    check_eq("b2b_max_x", max_x, 44);
    check_eq("b2b_min_y", min_y, 5);
    check_eq("b2b_max_y", max_y, 14);
    check_eq("b2b_colour_bad", col_bad, 0);
    check_eq("b2b_fin_count", n_fin, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
